// File: rtl/herculesae_vx_sha256su1_cpa.sv
// -----------------------------------------------------------------------------
// herculesae_vx_sha256su1_cpa
//
// Two-stage pipelined carry-propagate adder for the SHA256SU1 datapath.
// Resolves the sum/carry vector pair from the 3:2 compressor into two
// independent 32-bit lane sums. The result feeds the compressor's sumnr input
// and the newx writeback path.
//
// Ports:
//   clk        core clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   sum/carry pair valid this cycle
//   in_ready   block can accept the pair this cycle (combinational from out_ready)
//   in_sum     64-bit sum vector from the 3:2 stage
//   in_carry   64-bit carry vector, already shifted left one bit per lane
//   in_tag     opaque sideband tag, returned unchanged with the result
//   flush      kills all in-flight entries on the next edge
//   out_valid  result valid
//   out_ready  consumer accepts the result this cycle
//   out_sumnr  lane-resolved sum {hi lane, lo lane}
//   out_tag    tag of the result
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer; valid never depends on ready, while ready may depend on valid
// of the downstream stage. S2 holds its data and tag stable while
// out_valid is high and out_ready is low.
// -----------------------------------------------------------------------------
module herculesae_vx_sha256su1_cpa #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_sum,
    input  logic [63:0]      in_carry,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_sumnr,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_valid;
    logic [63:0]      s1_sum;
    logic [63:0]      s1_carry;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [63:0]      s2_result;
    logic [TAG_W-1:0] s2_tag;

    logic             s2_free;
    logic             s1_adv;
    logic             accept;
    logic [31:0]      lane_lo;
    logic [31:0]      lane_hi;

    assign s2_free  = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s1_adv;
    assign accept   = in_valid && in_ready;

    // Each lane is a separate 32-bit add, so no carry crosses bit 31 -> 32
    // and the carry out of each lane is dropped by the 32-bit result width.
    // Carry bits 0 and 32 are used as supplied.
    assign lane_lo = s1_sum[31:0]  + s1_carry[31:0];
    assign lane_hi = s1_sum[63:32] + s1_carry[63:32];

    // Valid bits: flush drops everything, including an accept in the same
    // cycle; in_ready is still reported as computed above.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                s2_valid <= 1'b1;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // Data/tag registers: loads are gated only by the handshake, since a
    // flushed entry's payload is never observed with its valid bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_sum    <= 64'd0;
            s1_carry  <= 64'd0;
            s1_tag    <= '0;
            s2_result <= 64'd0;
            s2_tag    <= '0;
        end else begin
            if (accept) begin
                s1_sum   <= in_sum;
                s1_carry <= in_carry;
                s1_tag   <= in_tag;
            end
            if (s1_adv) begin
                s2_result <= {lane_hi, lane_lo};
                s2_tag    <= s1_tag;
            end
        end
    end

    // Output stage is the S2 register bank directly; no logic follows it.
    assign out_valid = s2_valid;
    assign out_sumnr = s2_result;
    assign out_tag   = s2_tag;

endmodule

// File: tb/tb_herculesae_vx_sha256su1_cpa.sv
// -----------------------------------------------------------------------------
// tb_herculesae_vx_sha256su1_cpa
//
// Self-checking bench for herculesae_vx_sha256su1_cpa. A behavioural model
// tracks the in-flight entries as a queue of {tag, lane sums}, plus whether
// the oldest entry currently sits in the output stage.
// -----------------------------------------------------------------------------
module tb_herculesae_vx_sha256su1_cpa;

    localparam int TAG_W = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_sum;
    logic [63:0]      in_carry;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_sumnr;
    logic [TAG_W-1:0] out_tag;

    herculesae_vx_sha256su1_cpa #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sumnr (out_sumnr),
        .out_tag   (out_tag)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [63+TAG_W:0] exp_q[$];   // {tag, result}, oldest first
    bit                head_in_s2; // oldest model entry has reached the output stage
    int                n_checks;
    int                n_errors;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference: two independent 32-bit additions, each reduced modulo 2^32.
    function automatic logic [63:0] lane_model(input logic [63:0] s, input logic [63:0] c);
        longint unsigned lo, hi;
        lo = (longint'(s[31:0]) + longint'(c[31:0])) % 64'h1_0000_0000;
        hi = (longint'(s[63:32]) + longint'(c[63:32])) % 64'h1_0000_0000;
        return (hi << 32) | lo;
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic drive_cycle(input logic iv, input logic [63:0] s, input logic [63:0] c,
                               input logic [TAG_W-1:0] t, input logic ordy, input logic fl,
                               output logic acc);
        logic exp_ready;
        logic [63+TAG_W:0] head;
        @(negedge clk);
        in_valid  = iv;
        in_sum    = s;
        in_carry  = c;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
        #1;
        // Two stored entries fill the pipe; only a draining output frees a slot.
        exp_ready = (exp_q.size() < 2) || ordy;
        check_val("in_ready", 64'(in_ready), 64'(exp_ready));
        check_val("out_valid", 64'(out_valid), 64'(head_in_s2));
        if (head_in_s2 && ordy) begin
            head = exp_q.pop_front();
            check_val("out_sumnr", out_sumnr, head[63:0]);
            check_val("out_tag", 64'(out_tag), 64'(head[63+TAG_W:64]));
            head_in_s2 = 1'b0;
        end
        if (!head_in_s2 && exp_q.size() > 0) head_in_s2 = 1'b1;
        acc = iv && exp_ready;
        if (acc && !fl) exp_q.push_back({t, lane_model(s, c)});
        if (fl) begin
            exp_q.delete();
            head_in_s2 = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic ordy, input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 64'd0, 64'd0, '0, ordy, 1'b0, acc);
    endtask

    // Hold the pair on the bus until it is accepted (bounded).
    task automatic send(input logic [63:0] s, input logic [63:0] c, input logic [TAG_W-1:0] t,
                        input logic ordy);
        logic acc;
        int   tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            drive_cycle(1'b1, s, c, t, ordy, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: tag %0d not accepted within 50 cycles", t);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        n_checks   = 0;
        n_errors   = 0;
        head_in_s2 = 1'b0;
        in_valid   = 1'b0;
        in_sum     = 64'd0;
        in_carry   = 64'd0;
        in_tag     = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        reset      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_sumnr", out_sumnr, 64'd0);
        check_val("rst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Lane isolation: no carry from bit 31 into bit 32.
        send(64'hFFFFFFFF_00000001, 64'h00000002_FFFFFFFE, 4'h3, 1'b1);
        idle(1'b1, 3);
        check_val("iso_model", lane_model(64'hFFFFFFFF_00000001, 64'h00000002_FFFFFFFE),
                  64'h00000001_FFFFFFFF);

        // Lower-lane overflow wraps; upper lane untouched.
        send(64'h00000000_80000000, 64'h00000000_80000000, 4'h5, 1'b1);
        idle(1'b1, 3);
        // Carry bits 0 and 32 are honoured, and the top carry is dropped.
        send(64'hFFFFFFFF_FFFFFFFF, 64'h00000001_00000001, 4'h6, 1'b1);
        idle(1'b1, 3);

        // Backpressure: third input waits until the output drains.
        send(64'h11111111_22222222, 64'h00000010_00000020, 4'h0, 1'b0);
        send(64'h33333333_44444444, 64'h00000030_00000040, 4'h1, 1'b0);
        drive_cycle(1'b1, 64'h55555555_66666666, 64'h50, 4'h2, 1'b0, 1'b0, acc);
        drive_cycle(1'b1, 64'h55555555_66666666, 64'h50, 4'h2, 1'b0, 1'b0, acc);
        send(64'h55555555_66666666, 64'h50, 4'h2, 1'b1);
        idle(1'b1, 4);
        check_val("bp_drained", 64'(exp_q.size()), 64'd0);

        // Streaming: back-to-back random pairs with out_ready held high.
        for (int i = 0; i < 16; i++) begin
            send({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'b1);
        end
        idle(1'b1, 4);
        check_val("stream_drained", 64'(exp_q.size()), 64'd0);

        // Random valid/ready/occasional flush mix.
        for (int i = 0; i < 200; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                        4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 19) == 0), acc);
        end
        idle(1'b1, 4);

        // Flush with two held entries plus a same-cycle accept.
        send(64'h1, 64'h1, 4'h7, 1'b0);
        send(64'h2, 64'h2, 4'h8, 1'b0);
        drive_cycle(1'b1, 64'h3, 64'h3, 4'h9, 1'b1, 1'b1, acc);
        idle(1'b1, 2);
        send(64'hABCD0000_00001234, 64'h00001111_00002222, 4'hA, 1'b1);
        idle(1'b1, 4);
        check_val("flush_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with two entries held: outputs clear with no edge.
        send(64'h10, 64'h20, 4'hB, 1'b0);
        send(64'h30, 64'h40, 4'hC, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        check_val("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check_val("arst_out_valid", 64'(out_valid), 64'd0);
        check_val("arst_in_ready", 64'(in_ready), 64'd1);
        check_val("arst_out_sumnr", out_sumnr, 64'd0);
        check_val("arst_out_tag", 64'(out_tag), 64'd0);
        exp_q.delete();
        head_in_s2 = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;

        // Pipe works again after reset; nothing replayed.
        send(64'h00000005_00000007, 64'h00000006_00000008, 4'hD, 1'b1);
        idle(1'b1, 4);
        check_val("post_rst_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
